// File: rtl/smpl_pkg.sv
// smpl_pkg: shared types and default sizing for the smpl memory subsystem.
//   boot_state_t  - boot sequencer states (clear DMEM, load IMEM, run core)
//   *_DEF         - default widths/depths used as top-level parameter defaults
package smpl_pkg;

    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned ADDR_W_DEF     = 13;
    localparam int unsigned IMEM_DEPTH_DEF = 128;
    localparam int unsigned DMEM_DEPTH_DEF = 128;

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StLoad  = 2'd1,
        StRun   = 2'd2
    } boot_state_t;

endpackage

// File: rtl/smpl_sram.sv
// smpl_sram: single-port synchronous RAM with a registered one-cycle read.
// A read and a write in the same cycle return the old contents (read-before-write).
// The read register only updates when i_re is high, so o_rdata holds otherwise.
// Ports:
//   i_clk    clock, rising edge
//   i_we     write enable
//   i_re     read enable
//   i_addr   word address (caller guarantees it is below DEPTH)
//   i_wdata  write data
//   o_rdata  registered read data
module smpl_sram #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/smpl_memsys.sv
// smpl_memsys: IMEM + DMEM for the smpl core with a boot sequencer.
// After reset the sequencer clears DMEM one word per cycle, then accepts IMEM
// words from a streaming loader, then releases the core and serves its fetch
// and data ports with one-cycle registered reads.
// Ports:
//   i_clock, i_reset               clock; synchronous active-low reset
//   o_core_rst_n, o_boot_done      core reset release / boot complete (RUN)
//   i_iaddr, o_idata               instruction fetch
//   i_daddr, i_datao, i_renbl,
//   i_wenbl, o_datai, o_dvalid     core data port
//   i_ld_valid, o_ld_ready,
//   i_ld_addr, i_ld_data,
//   i_ld_last                      IMEM loader stream
//   o_addr_err                     sticky out-of-range flag
module smpl_memsys
    import smpl_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    output logic              o_core_rst_n,
    input  logic [ADDR_W-1:0] i_iaddr,
    output logic [DATA_W-1:0] o_idata,
    input  logic [ADDR_W-1:0] i_daddr,
    input  logic [DATA_W-1:0] i_datao,
    input  logic              i_renbl,
    input  logic              i_wenbl,
    output logic [DATA_W-1:0] o_datai,
    output logic              o_dvalid,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_last,
    output logic              o_boot_done,
    output logic              o_addr_err
);

    localparam int unsigned IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0]  IMEM_LIM  = ADDR_W'(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0]  DMEM_LIM  = ADDR_W'(DMEM_DEPTH);
    localparam logic [DMEM_AW-1:0] CLR_LAST  = DMEM_AW'(DMEM_DEPTH - 1);

    boot_state_t        r_state;
    logic [DMEM_AW-1:0] r_clr_cnt;
    logic               r_ld_ready;
    logic               r_boot_done;
    logic               r_core_rst_n;

    // Mask flags: when set, the corresponding read output is forced to zero
    // (reset, or last request was out of range).
    logic r_imask;
    logic r_dmask;
    logic r_dvalid;
    logic r_addr_err;

    logic               w_clear;
    logic               w_load;
    logic               w_run;
    logic               w_ld_fire;
    logic               w_ld_in;
    logic               w_i_in;
    logic               w_d_in;
    logic               w_err_set;
    logic               w_imem_we;
    logic               w_imem_re;
    logic [IMEM_AW-1:0] w_imem_addr;
    logic [DATA_W-1:0]  w_imem_rdata;
    logic               w_dmem_we;
    logic               w_dmem_re;
    logic [DMEM_AW-1:0] w_dmem_addr;
    logic [DATA_W-1:0]  w_dmem_wdata;
    logic [DATA_W-1:0]  w_dmem_rdata;

    // Gating with i_reset keeps memories untouched on the reset edge itself.
    assign w_clear   = (r_state == StClear) && i_reset;
    assign w_load    = (r_state == StLoad) && i_reset;
    assign w_run     = (r_state == StRun) && i_reset;
    assign w_ld_fire = w_load && i_ld_valid;

    // Full-width compares: no aliasing of high address bits.
    assign w_ld_in = (i_ld_addr < IMEM_LIM);
    assign w_i_in  = (i_iaddr < IMEM_LIM);
    assign w_d_in  = (i_daddr < DMEM_LIM);

    assign w_err_set = (w_ld_fire && !w_ld_in)
                     || (w_run && !w_i_in)
                     || (w_run && (i_renbl || i_wenbl) && !w_d_in);

    // IMEM port: loader owns it in LOAD, fetch owns it in RUN.
    always_comb begin
        w_imem_we   = w_ld_fire && w_ld_in;
        w_imem_re   = w_run && w_i_in;
        w_imem_addr = w_load ? i_ld_addr[IMEM_AW-1:0] : i_iaddr[IMEM_AW-1:0];
    end

    // DMEM port: clear counter owns it in CLEAR, the core in RUN.
    always_comb begin
        w_dmem_we    = w_clear || (w_run && i_wenbl && w_d_in);
        w_dmem_re    = w_run && i_renbl && w_d_in;
        w_dmem_addr  = w_clear ? r_clr_cnt : i_daddr[DMEM_AW-1:0];
        w_dmem_wdata = w_clear ? '0 : i_datao;
    end

    smpl_sram #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (DATA_W)
    ) u_imem (
        .i_clk   (i_clock),
        .i_we    (w_imem_we),
        .i_re    (w_imem_re),
        .i_addr  (w_imem_addr),
        .i_wdata (i_ld_data),
        .o_rdata (w_imem_rdata)
    );

    smpl_sram #(
        .DEPTH (DMEM_DEPTH),
        .WIDTH (DATA_W)
    ) u_dmem (
        .i_clk   (i_clock),
        .i_we    (w_dmem_we),
        .i_re    (w_dmem_re),
        .i_addr  (w_dmem_addr),
        .i_wdata (w_dmem_wdata),
        .o_rdata (w_dmem_rdata)
    );

    // Boot sequencer with registered status outputs.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= StClear;
            r_clr_cnt    <= '0;
            r_ld_ready   <= 1'b0;
            r_boot_done  <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            case (r_state)
                StClear: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state    <= StLoad;
                        r_ld_ready <= 1'b1;
                    end
                end
                StLoad: begin
                    if (i_ld_valid && i_ld_last) begin
                        r_state      <= StRun;
                        r_ld_ready   <= 1'b0;
                        r_boot_done  <= 1'b1;
                        r_core_rst_n <= 1'b1;
                    end
                end
                StRun: begin
                    r_state <= StRun;
                end
                default: begin
                    r_state <= StClear;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_imask    <= 1'b1;
            r_dmask    <= 1'b1;
            r_dvalid   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_run) begin
                r_imask <= !w_i_in;
            end
            if (w_run && i_renbl) begin
                r_dmask <= !w_d_in;
            end
            r_dvalid <= w_run && i_renbl;
            if (w_err_set) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign o_idata      = r_imask ? '0 : w_imem_rdata;
    assign o_datai      = r_dmask ? '0 : w_dmem_rdata;
    assign o_dvalid     = r_dvalid;
    assign o_addr_err   = r_addr_err;
    assign o_ld_ready   = r_ld_ready;
    assign o_boot_done  = r_boot_done;
    assign o_core_rst_n = r_core_rst_n;

endmodule

// File: tb/tb_smpl_memsys.sv
// Testbench for smpl_memsys: boot sequence, table-driven load/run vectors,
// randomized core traffic against an array model, and reset/reboot sequences.
module tb_smpl_memsys;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int DD = 128;
    localparam int ID = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_rst_n;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic [AW-1:0] daddr;
    logic [DW-1:0] datao;
    logic          renbl;
    logic          wenbl;
    logic [DW-1:0] datai;
    logic          dvalid;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          boot_done;
    logic          addr_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    smpl_memsys #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .IMEM_DEPTH (ID),
        .DMEM_DEPTH (DD)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .o_core_rst_n (core_rst_n),
        .i_iaddr      (iaddr),
        .o_idata      (idata),
        .i_daddr      (daddr),
        .i_datao      (datao),
        .i_renbl      (renbl),
        .i_wenbl      (wenbl),
        .o_datai      (datai),
        .o_dvalid     (dvalid),
        .i_ld_valid   (ld_valid),
        .o_ld_ready   (ld_ready),
        .i_ld_addr    (ld_addr),
        .i_ld_data    (ld_data),
        .i_ld_last    (ld_last),
        .o_boot_done  (boot_done),
        .o_addr_err   (addr_err)
    );

    typedef struct {
        logic          ld_valid;
        logic [AW-1:0] ld_addr;
        logic [DW-1:0] ld_data;
        logic          ld_last;
        logic [AW-1:0] iaddr;
        logic [AW-1:0] daddr;
        logic [DW-1:0] datao;
        logic          renbl;
        logic          wenbl;
        logic          e_ld_ready;
        logic          e_boot;
        logic          e_core;
        logic [DW-1:0] e_idata;
        logic          e_dvalid;
        logic [DW-1:0] e_datai;
        logic          e_err;
    } vec_t;

    function automatic vec_t mk(input int lv, input int la, input int ld, input int ll,
                                input int ia, input int da, input int dout, input int re,
                                input int we, input int rdy, input int bd, input int cr,
                                input int eid, input int edv, input int edi, input int eer);
        vec_t v;
        v.ld_valid   = lv[0];
        v.ld_addr    = AW'(la);
        v.ld_data    = DW'(ld);
        v.ld_last    = ll[0];
        v.iaddr      = AW'(ia);
        v.daddr      = AW'(da);
        v.datao      = DW'(dout);
        v.renbl      = re[0];
        v.wenbl      = we[0];
        v.e_ld_ready = rdy[0];
        v.e_boot     = bd[0];
        v.e_core     = cr[0];
        v.e_idata    = DW'(eid);
        v.e_dvalid   = edv[0];
        v.e_datai    = DW'(edi);
        v.e_err      = eer[0];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        ld_last  = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        datao    = '0;
        renbl    = 1'b0;
        wenbl    = 1'b0;
    endtask

    task automatic chk_reset_outs(input int idx);
        chk("rst_core_rst_n", idx, 32'(core_rst_n), 32'd0);
        chk("rst_idata", idx, 32'(idata), 32'd0);
        chk("rst_datai", idx, 32'(datai), 32'd0);
        chk("rst_dvalid", idx, 32'(dvalid), 32'd0);
        chk("rst_ld_ready", idx, 32'(ld_ready), 32'd0);
        chk("rst_boot_done", idx, 32'(boot_done), 32'd0);
        chk("rst_addr_err", idx, 32'(addr_err), 32'd0);
    endtask

    // Release reset and walk through exactly DMEM-depth clear cycles.
    task automatic boot_clear(input int idx);
        int bad;
        bad   = 0;
        rst_n = 1'b1;
        for (int k = 0; k < DD - 1; k++) begin
            tick();
            if (ld_ready !== 1'b0 || core_rst_n !== 1'b0 || boot_done !== 1'b0) bad++;
        end
        chk("clear_hold_cycles", idx, 32'(bad), 32'd0);
        tick();
        chk("ld_ready_rise", idx, 32'(ld_ready), 32'd1);
        chk("core_rst_after_clear", idx, 32'(core_rst_n), 32'd0);
    endtask

    task automatic load_beat(input int a, input int d, input int last);
        ld_valid = 1'b1;
        ld_addr  = AW'(a);
        ld_data  = DW'(d);
        ld_last  = last[0];
        tick();
        drive_idle();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          tbl[15];
        logic [DW-1:0] m_dmem[DD];
        logic [DW-1:0] m_imem[4];
        logic [DW-1:0] e_di;
        logic [DW-1:0] e_id;
        logic          e_dv;

        tbl[0]  = mk(1, 0, 'h1111, 0,  0,   0,      0, 0, 0,  1, 0, 0,      0, 0,      0, 0);
        tbl[1]  = mk(1, 1, 'h2222, 0,  0,   0,      0, 0, 0,  1, 0, 0,      0, 0,      0, 0);
        tbl[2]  = mk(1, 2, 'h3333, 0,  0,   0,      0, 0, 0,  1, 0, 0,      0, 0,      0, 0);
        tbl[3]  = mk(1, 3, 'h4444, 1,  0,   0,      0, 0, 0,  0, 1, 1,      0, 0,      0, 0);
        tbl[4]  = mk(0, 0, 0,      0,  2,   5, 'hBEEF, 0, 1,  0, 1, 1, 'h3333, 0,      0, 0);
        tbl[5]  = mk(0, 0, 0,      0,  3,   5,      0, 1, 0,  0, 1, 1, 'h4444, 1, 'hBEEF, 0);
        tbl[6]  = mk(0, 0, 0,      0,  0,   6,      0, 1, 0,  0, 1, 1, 'h1111, 1,      0, 0);
        tbl[7]  = mk(0, 0, 0,      0,  1,   7, 'hAAAA, 1, 1,  0, 1, 1, 'h2222, 1,      0, 0);
        tbl[8]  = mk(0, 0, 0,      0,  1,   7,      0, 1, 0,  0, 1, 1, 'h2222, 1, 'hAAAA, 0);
        tbl[9]  = mk(0, 0, 0,      0,  1,   7,      0, 0, 0,  0, 1, 1, 'h2222, 0, 'hAAAA, 0);
        tbl[10] = mk(0, 0, 0,      0,  1, 200,      0, 1, 0,  0, 1, 1, 'h2222, 1,      0, 1);
        tbl[11] = mk(0, 0, 0,      0,  1, 200, 'h1234, 0, 1,  0, 1, 1, 'h2222, 0,      0, 1);
        tbl[12] = mk(0, 0, 0,      0,  1,  72,      0, 1, 0,  0, 1, 1, 'h2222, 1,      0, 1);
        tbl[13] = mk(1, 0, 'hFFFF, 1,  0,   0,      0, 0, 0,  0, 1, 1, 'h1111, 0,      0, 1);
        tbl[14] = mk(0, 0, 0,      0,  0,   0,      0, 0, 0,  0, 1, 1, 'h1111, 0,      0, 1);

        // Power-on reset.
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk_reset_outs(0);
        boot_clear(0);

        // Table: load IMEM[0..3], then core traffic and out-of-range cases.
        foreach (tbl[i]) begin
            ld_valid = tbl[i].ld_valid;
            ld_addr  = tbl[i].ld_addr;
            ld_data  = tbl[i].ld_data;
            ld_last  = tbl[i].ld_last;
            iaddr    = tbl[i].iaddr;
            daddr    = tbl[i].daddr;
            datao    = tbl[i].datao;
            renbl    = tbl[i].renbl;
            wenbl    = tbl[i].wenbl;
            tick();
            chk("tbl_ld_ready", i, 32'(ld_ready), 32'(tbl[i].e_ld_ready));
            chk("tbl_boot_done", i, 32'(boot_done), 32'(tbl[i].e_boot));
            chk("tbl_core_rst_n", i, 32'(core_rst_n), 32'(tbl[i].e_core));
            chk("tbl_idata", i, 32'(idata), 32'(tbl[i].e_idata));
            chk("tbl_dvalid", i, 32'(dvalid), 32'(tbl[i].e_dvalid));
            chk("tbl_datai", i, 32'(datai), 32'(tbl[i].e_datai));
            chk("tbl_addr_err", i, 32'(addr_err), 32'(tbl[i].e_err));
        end
        drive_idle();

        // Reference memory contents after the table.
        foreach (m_dmem[a]) m_dmem[a] = '0;
        m_dmem[5] = 16'hBEEF;
        m_dmem[7] = 16'hAAAA;
        m_imem[0] = 16'h1111;
        m_imem[1] = 16'h2222;
        m_imem[2] = 16'h3333;
        m_imem[3] = 16'h4444;
        e_di = '0;

        // Randomized core traffic against the array model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) daddr = AW'($urandom_range(DD, (1 << AW) - 1));
            else                           daddr = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) iaddr = AW'($urandom_range(ID, (1 << AW) - 1));
            else                            iaddr = AW'($urandom_range(0, 3));
            renbl = 1'($urandom_range(0, 1));
            wenbl = 1'($urandom_range(0, 1));
            datao = DW'($urandom);

            e_dv = renbl;
            if (renbl) e_di = (int'(daddr) < DD) ? m_dmem[daddr] : '0;
            if (wenbl && int'(daddr) < DD) m_dmem[daddr] = datao;
            e_id = (int'(iaddr) < 4) ? m_imem[iaddr[1:0]] : '0;

            tick();
            chk("rnd_dvalid", c, 32'(dvalid), 32'(e_dv));
            chk("rnd_datai", c, 32'(datai), 32'(e_di));
            chk("rnd_idata", c, 32'(idata), 32'(e_id));
            chk("rnd_addr_err", c, 32'(addr_err), 32'd1);
        end
        drive_idle();

        // Reset from RUN, reboot, then reset again part-way through LOAD.
        rst_n = 1'b0;
        tick();
        chk_reset_outs(1);
        boot_clear(1);
        load_beat(8, 'h5555, 0);
        load_beat(9, 'h6666, 0);
        chk("load_mid_boot_done", 0, 32'(boot_done), 32'd0);
        rst_n = 1'b0;
        tick();
        chk_reset_outs(2);
        boot_clear(2);

        // Out-of-range loader beat: accepted, dropped, flags error.
        load_beat(300, 'hDEAD, 0);
        chk("ld_oor_err", 0, 32'(addr_err), 32'd1);
        chk("ld_oor_ready", 0, 32'(ld_ready), 32'd1);
        chk("ld_oor_boot", 0, 32'(boot_done), 32'd0);
        load_beat(10, 'h7777, 1);
        chk("reboot_done", 0, 32'(boot_done), 32'd1);
        chk("reboot_core", 0, 32'(core_rst_n), 32'd1);
        chk("reboot_ld_ready", 0, 32'(ld_ready), 32'd0);

        // IMEM survives resets; DMEM was re-cleared.
        iaddr = AW'(8);
        tick();
        chk("keep_imem8", 0, 32'(idata), 32'h5555);
        iaddr = AW'(9);
        tick();
        chk("keep_imem9", 0, 32'(idata), 32'h6666);
        iaddr = AW'(10);
        renbl = 1'b1;
        daddr = AW'(5);
        tick();
        chk("new_imem10", 0, 32'(idata), 32'h7777);
        chk("dmem_recleared", 0, 32'(datai), 32'd0);
        chk("dmem_recleared_v", 0, 32'(dvalid), 32'd1);
        renbl = 1'b0;
        iaddr = AW'(0);
        tick();
        chk("keep_imem0", 0, 32'(idata), 32'h1111);
        iaddr = AW'(500);
        tick();
        chk("fetch_oor_zero", 0, 32'(idata), 32'd0);
        chk("fetch_oor_err", 0, 32'(addr_err), 32'd1);
        drive_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
